// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM AXI-Lite register front end.
// No logic here: response codes, FSM state encodings and size helpers.
// No backpressure: constants and functions only.
package pwm_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_CAPT = 2'd2,
        R_RESP = 2'd3
    } r_state_t;

    // One global register followed by a period/duty pair per channel.
    function automatic int calc_depth(input int num_channels);
        return 1 + 2 * num_channels;
    endfunction

    function automatic int calc_addr_width(input int num_channels);
        return $clog2(calc_depth(num_channels));
    endfunction

endpackage

// File: rtl/pwm_axil_ctrl.sv
// AXI-Lite slave bridging to a simple register-file write/read port for the PWM block.
// Latency: AW+W -> write_en next cycle -> bvalid after; AR -> read_en next cycle -> rvalid 2 after.
// Backpressure: one outstanding write and one outstanding read; ready low until the response is taken.
module pwm_axil_ctrl
    import pwm_pkg::*;
#(
    parameter int REG_WIDTH      = 16,
    parameter int NUM_CHANNELS   = 4,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 32,
    localparam int DEPTH         = calc_depth(NUM_CHANNELS),
    localparam int ADDR_WIDTH    = calc_addr_width(NUM_CHANNELS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                          s_awvalid,
    output logic                          s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                          s_wvalid,
    output logic                          s_wready,
    output logic [1:0]                    s_bresp,
    output logic                          s_bvalid,
    input  logic                          s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_araddr,
    input  logic                          s_arvalid,
    output logic                          s_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rvalid,
    input  logic                          s_rready,
    output logic                          write_en,
    output logic [ADDR_WIDTH-1:0]         write_addr,
    output logic [REG_WIDTH-1:0]          write_data,
    output logic                          read_en,
    output logic [ADDR_WIDTH-1:0]         read_addr,
    input  logic [REG_WIDTH-1:0]          read_data,
    input  logic                          read_valid
);

    localparam int                    STRB_BYTES = (REG_WIDTH + 7) / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W    = DEPTH[ADDR_WIDTH:0];

    // Word index must be below DEPTH and no address bits above the index may be set.
    function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] idx_ext;
        idx_ext = {1'b0, a[ADDR_WIDTH+1:2]};
        return ((a >> (ADDR_WIDTH + 2)) == '0) && (idx_ext < DEPTH_W);
    endfunction

    w_state_t                    w_state, w_next;
    logic                        aw_held, w_held;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb_q;
    logic                        aw_fire, w_fire, wr_ok;

    r_state_t                    r_state, r_next;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                  rresp_q;
    logic                        ar_fire, rd_ok;

    // Byte-offset bits and write data above REG_WIDTH are accepted but carry no meaning.
    logic unused_bits;
    assign unused_bits = ^{aw_addr_q, ar_addr_q, w_data_q, w_strb_q};

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;
    assign ar_fire = s_arvalid && s_arready;

    // Partial-strobe writes are refused rather than merged: the register file has no byte enables.
    assign wr_ok = addr_in_range(aw_addr_q) && (&w_strb_q[STRB_BYTES-1:0]);
    assign rd_ok = addr_in_range(ar_addr_q);

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next state: proceed once both address and data are in hand
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if ((aw_held || aw_fire) && (w_held || w_fire)) w_next = W_EXEC;
            W_EXEC:  w_next = W_RESP;
            W_RESP:  if (s_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // AW and W are captured independently; flags clear when the response is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (w_state == W_RESP && s_bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_awaddr;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
        end
    end

    // Write FSM outputs
    always_comb begin
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        s_bvalid   = 1'b0;
        s_bresp    = RESP_OKAY;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        case (w_state)
            W_IDLE: begin
                s_awready = !aw_held;
                s_wready  = !w_held;
            end
            W_EXEC: begin
                write_en = wr_ok;
                if (wr_ok) begin
                    write_addr = aw_addr_q[ADDR_WIDTH+1:2];
                    write_data = w_data_q[REG_WIDTH-1:0];
                end
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            default: ;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_EXEC;
            R_EXEC:  r_next = R_CAPT;
            R_CAPT:  r_next = R_RESP;
            R_RESP:  if (s_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Latch the read address, then capture the register-file return; no return means SLVERR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (ar_fire) ar_addr_q <= s_araddr;
            if (r_state == R_CAPT) begin
                rdata_q <= read_valid ? AXI_DATA_WIDTH'(read_data) : '0;
                rresp_q <= read_valid ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Read FSM outputs
    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = RESP_OKAY;
        read_en   = 1'b0;
        read_addr = '0;
        case (r_state)
            R_IDLE: s_arready = 1'b1;
            R_EXEC: begin
                read_en = rd_ok;
                if (rd_ok) read_addr = ar_addr_q[ADDR_WIDTH+1:2];
            end
            R_RESP: begin
                s_rvalid = 1'b1;
                s_rdata  = rdata_q;
                s_rresp  = rresp_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pwm_axil_ctrl.sv
// Directed bench for pwm_axil_ctrl with a behavioural register file on the back end.
// Inputs are driven and outputs sampled on the falling clock edge.
// The response channels are stalled explicitly where a scenario needs it.
module tb_pwm_axil_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [7:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic        read_en;
    logic [3:0]  read_addr;
    logic [15:0] read_data;
    logic        read_valid;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;
    int rd_count = 0;

    logic [15:0] mem [0:8];

    pwm_axil_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_awaddr   (s_awaddr),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_bresp    (s_bresp),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_valid (read_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: returns the pre-write value one cycle after read_en
    always @(posedge clk) begin
        read_valid <= read_en;
        if (read_en && read_addr < 4'd9) read_data <= mem[read_addr];
        if (write_en && write_addr < 4'd9) mem[write_addr] <= write_data;
        if (write_en) wr_count <= wr_count + 1;
        if (read_en)  rd_count <= rd_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int pulses);
        int   c0, g;
        logic aw_done, w_done;
        c0 = wr_count;
        @(negedge clk);
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        s_bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; g = 0;
        while (!(aw_done && w_done) && g < 20) begin
            if (s_awvalid && s_awready) aw_done = 1'b1;
            if (s_wvalid && s_wready)   w_done  = 1'b1;
            @(negedge clk);
            g++;
            if (aw_done) s_awvalid = 1'b0;
            if (w_done)  s_wvalid  = 1'b0;
        end
        check("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
        g = 0;
        while (!s_bvalid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("wr_bvalid_seen", {31'd0, s_bvalid}, 32'd1);
        resp = s_bresp;
        @(negedge clk);
        pulses = wr_count - c0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int pulses);
        int c0, g;
        c0 = rd_count;
        @(negedge clk);
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b0;
        g = 0;
        while (!s_arready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("rd_handshake", {31'd0, s_arready}, 32'd1);
        @(negedge clk);
        s_arvalid = 1'b0;
        g = 0;
        while (!s_rvalid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("rd_rvalid_seen", {31'd0, s_rvalid}, 32'd1);
        data = s_rdata;
        resp = s_rresp;
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        pulses = rd_count - c0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          n, c0;

        for (int i = 0; i < 9; i++) mem[i] = 16'h0000;
        read_data = '0; read_valid = 1'b0;
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bvalid",   {31'd0, s_bvalid}, 32'd0);
        check("rst_rvalid",   {31'd0, s_rvalid}, 32'd0);
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_read_en",  {31'd0, read_en},  32'd0);
        check("rst_bresp",    {30'd0, s_bresp},  32'd0);
        check("rst_rresp",    {30'd0, s_rresp},  32'd0);
        check("rst_rdata",    s_rdata,           32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

        // AW and W together to 0x04
        c0 = wr_count;
        s_awaddr = 8'h04; s_awvalid = 1'b1;
        s_wdata = 32'h1234; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("t1_write_en",   {31'd0, write_en},   32'd1);
        check("t1_write_addr", {28'd0, write_addr}, 32'd1);
        check("t1_write_data", {16'd0, write_data}, 32'h1234);
        check("t1_bvalid_early", {31'd0, s_bvalid}, 32'd0);
        check("t1_aw_blocked", {30'd0, s_awready, s_wready}, 32'd0);
        @(negedge clk);
        check("t1_write_en_off", {31'd0, write_en},   32'd0);
        check("t1_waddr_zero",   {28'd0, write_addr}, 32'd0);
        check("t1_bvalid",       {31'd0, s_bvalid},   32'd1);
        check("t1_bresp",        {30'd0, s_bresp},    32'd0);
        @(negedge clk);
        check("t1_bvalid_done", {31'd0, s_bvalid}, 32'd0);
        check("t1_pulses",      wr_count - c0,     32'd1);
        check("t1_mem",         {16'd0, mem[1]},   32'h1234);

        // W first, AW three cycles later
        c0 = wr_count;
        s_wdata = 32'h00AB; s_wstrb = 4'hF; s_wvalid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            s_wvalid = 1'b0;
            check("t2_no_early_write", {31'd0, write_en}, 32'd0);
            check("t2_wready_low",     {31'd0, s_wready}, 32'd0);
            check("t2_awready_high",   {31'd0, s_awready}, 32'd1);
            if (i == 3) begin
                s_awaddr = 8'h08; s_awvalid = 1'b1;
            end
        end
        @(negedge clk);
        s_awvalid = 1'b0;
        check("t2_write_en",   {31'd0, write_en},   32'd1);
        check("t2_write_addr", {28'd0, write_addr}, 32'd2);
        check("t2_write_data", {16'd0, write_data}, 32'h00AB);
        @(negedge clk);
        check("t2_bvalid", {31'd0, s_bvalid}, 32'd1);
        check("t2_bresp",  {30'd0, s_bresp},  32'd0);
        @(negedge clk);
        check("t2_pulses", wr_count - c0, 32'd1);

        // Read 0x04 with rready stalled
        s_araddr = 8'h04; s_arvalid = 1'b1; s_rready = 1'b0;
        @(negedge clk);
        s_arvalid = 1'b0;
        check("t3_read_en",   {31'd0, read_en},   32'd1);
        check("t3_read_addr", {28'd0, read_addr}, 32'd1);
        check("t3_arready_low", {31'd0, s_arready}, 32'd0);
        @(negedge clk);
        check("t3_read_en_off", {31'd0, read_en},  32'd0);
        check("t3_rvalid_capt", {31'd0, s_rvalid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_rvalid_hold", {31'd0, s_rvalid}, 32'd1);
            check("t3_rdata_hold",  s_rdata,           32'h00001234);
            check("t3_rresp_hold",  {30'd0, s_rresp},  32'd0);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        check("t3_rvalid_done", {31'd0, s_rvalid}, 32'd0);

        // Out-of-range index 9
        axi_write(8'h24, 32'hDEAD, 4'hF, rsp, n);
        check("t4_wr_bresp",  {30'd0, rsp}, 32'd2);
        check("t4_wr_pulses", n,            32'd0);
        axi_read(8'h24, rd, rsp, n);
        check("t4_rd_rresp",  {30'd0, rsp}, 32'd2);
        check("t4_rd_rdata",  rd,           32'd0);
        check("t4_rd_pulses", n,            32'd0);

        // Upper address bit set aliases index 1 but is out of range
        axi_read(8'h44, rd, rsp, n);
        check("t4b_rd_rresp",  {30'd0, rsp}, 32'd2);
        check("t4b_rd_pulses", n,            32'd0);

        // Partial strobe refused; low two bytes suffice for a 16-bit register
        axi_write(8'h00, 32'h5A5A, 4'h1, rsp, n);
        check("t5_bresp",  {30'd0, rsp}, 32'd2);
        check("t5_pulses", n,            32'd0);
        axi_write(8'h00, 32'h00C3, 4'h3, rsp, n);
        check("t5b_bresp",  {30'd0, rsp},    32'd0);
        check("t5b_pulses", n,               32'd1);
        check("t5b_mem",    {16'd0, mem[0]}, 32'h00C3);

        // Last valid index
        axi_write(8'h20, 32'h0F0F, 4'hF, rsp, n);
        check("t5c_bresp", {30'd0, rsp}, 32'd0);
        axi_read(8'h20, rd, rsp, n);
        check("t5c_rdata", rd,           32'h00000F0F);
        check("t5c_rresp", {30'd0, rsp}, 32'd0);

        // Concurrent read and write to the same index return the old value
        @(negedge clk);
        s_araddr = 8'h04; s_arvalid = 1'b1; s_rready = 1'b1;
        s_awaddr = 8'h04; s_awvalid = 1'b1;
        s_wdata = 32'h5555; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("t6_both_en", {30'd0, read_en, write_en}, 32'd3);
        @(negedge clk);
        check("t6_bvalid", {31'd0, s_bvalid}, 32'd1);
        @(negedge clk);
        check("t6_rvalid", {31'd0, s_rvalid}, 32'd1);
        check("t6_rdata_old", s_rdata,        32'h00001234);
        @(negedge clk);
        s_rready = 1'b0;
        axi_read(8'h04, rd, rsp, n);
        check("t6_rdata_new", rd, 32'h00005555);

        // Reset while write waits in W_RESP and read sits in R_CAPT
        @(negedge clk);
        s_awaddr = 8'h0C; s_awvalid = 1'b1;
        s_wdata = 32'h7777; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_bready = 1'b0; s_rready = 1'b0;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 8'h04; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        check("t7_bvalid_pre", {31'd0, s_bvalid}, 32'd1);
        @(negedge clk);
        check("t7_rvalid_capt", {31'd0, s_rvalid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t7_bvalid_rst", {31'd0, s_bvalid}, 32'd0);
        check("t7_rvalid_rst", {31'd0, s_rvalid}, 32'd0);
        check("t7_write_en_rst", {31'd0, write_en}, 32'd0);
        c0 = wr_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t7_no_write_after", wr_count - c0, 32'd0);
        check("t7_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
        check("t7_bvalid_idle", {31'd0, s_bvalid}, 32'd0);
        axi_write(8'h08, 32'hBEEF, 4'hF, rsp, n);
        check("t7_post_bresp",  {30'd0, rsp}, 32'd0);
        check("t7_post_pulses", n,            32'd1);
        axi_read(8'h08, rd, rsp, n);
        check("t7_post_rdata", rd,           32'h0000BEEF);
        check("t7_post_rresp", {30'd0, rsp}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_axil_ctrl.md
PWM_AXIL_CTRL -- requirements
Module: pwm_axil_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): REG_WIDTH, 16, register data width; NUM_CHANNELS, 4, PWM channels; AXI_ADDR_WIDTH, 8, AXI byte-address width; AXI_DATA_WIDTH, 32, AXI data width.
REQ-002 Derived constants SHALL be DEPTH = 1 + 2*NUM_CHANNELS and ADDR_WIDTH = $clog2(DEPTH).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_awaddr/s_awvalid/s_awready  in/in/out  AXI_ADDR_WIDTH/1/1  write address channel.
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  write data channel.
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel.
- s_araddr/s_arvalid/s_arready  in/in/out  AXI_ADDR_WIDTH/1/1  read address channel.
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  AXI_DATA_WIDTH/2/1/1  read data channel.
- write_en/write_addr/write_data  out/out/out  1/ADDR_WIDTH/REG_WIDTH  register-file write port.
- read_en/read_addr  out/out  1/ADDR_WIDTH  register-file read request.
- read_data/read_valid  in/in  REG_WIDTH/1  register-file read return, one cycle after read_en.

Function
REQ-004 Register index SHALL be byte address bits [ADDR_WIDTH+1:2]; bits [1:0] ignored; index >= DEPTH or any nonzero bit above ADDR_WIDTH+1 is out of range.
REQ-005 Write FSM states SHALL be W_IDLE, W_EXEC, W_RESP; read FSM states R_IDLE, R_EXEC, R_CAPT, R_RESP; both FSMs independent and may run concurrently.
REQ-006 In W_IDLE, s_awready SHALL equal !aw_held and s_wready SHALL equal !w_held; AW and W captured independently, in any order or the same cycle.
REQ-007 When both AW and W are held (including captured this edge), next state SHALL be W_EXEC; ready outputs low in W_EXEC and W_RESP.
REQ-008 In W_EXEC, write_en SHALL be high for exactly one cycle iff address in range and s_wstrb covers all bytes of REG_WIDTH; write_addr = index, write_data = s_wdata[REG_WIDTH-1:0].
REQ-009 W_RESP SHALL assert s_bvalid with s_bresp OKAY (2'b00) or SLVERR (2'b10, when write suppressed), held stable until s_bready, then W_IDLE and held flags cleared.
REQ-010 In R_IDLE, s_arready SHALL be 1; on handshake latch address, go R_EXEC.
REQ-011 In R_EXEC, read_en SHALL be high one cycle iff in range, with read_addr = index; next R_CAPT.
REQ-012 In R_CAPT, if read_valid then s_rdata = zero-extended read_data, s_rresp OKAY; else s_rdata = 0, s_rresp SLVERR; next R_RESP.
REQ-013 R_RESP SHALL hold s_rvalid, s_rdata, s_rresp stable until s_rready, then R_IDLE.
REQ-014 Latency: AW+W same edge -> write_en next cycle -> s_bvalid cycle after; AR edge -> read_en next cycle -> s_rvalid two cycles after read_en.
REQ-015 Read and write to same index in same cycle SHALL return the pre-write value.
REQ-016 write_en, read_en SHALL be low outside W_EXEC/R_EXEC; write_addr, write_data, read_addr SHALL be 0 when their enables are low.

Reset
REQ-017 On rst_n low, both FSMs SHALL enter *_IDLE, held flags clear; s_bvalid, s_rvalid, write_en, read_en low; s_bresp, s_rresp, s_rdata zero; s_awready, s_wready, s_arready high one cycle after deassertion.
REQ-018 Reset mid-transaction SHALL abandon it with no register-file write issued afterward.

Structure
REQ-019 Shared package pwm_pkg SHALL hold AXI response constants (OKAY, SLVERR), write/read FSM state enums, and DEPTH/ADDR_WIDTH derivation function.
REQ-020 No sub-module is required; both FSMs SHALL be implemented inline in pwm_axil_ctrl.

Verification
REQ-021 AW 0x04 and W 0x1234 (wstrb 0xF) same cycle, bready=1 -> write_en one cycle, write_addr 1, write_data 0x1234, bvalid next cycle, bresp OKAY.
REQ-022 W 0x00AB at cycle 0, AW 0x08 at cycle 3 -> no write_en before cycle 4, write_addr 2, bresp OKAY.
REQ-023 Read 0x04 after REQ-021 write, rready held low 5 cycles -> rdata 0x00001234 stable, rresp OKAY until rready.
REQ-024 Write 0x24 (index 9, DEPTH 9) -> no write_en, bresp SLVERR; read 0x24 -> no read_en, rdata 0, rresp SLVERR.
REQ-025 Write wstrb 0x1 to 0x00 -> no write_en, bresp SLVERR.
REQ-026 rst_n low during W_RESP and R_CAPT -> bvalid, rvalid low immediately; no write_en after release; next write completes normally.
